// File: rtl/oscill_nios_audio_i2s_tx.sv
// I2S DAC transmitter: stereo-frame FIFO, BCLK = clk/4, LRCLK = clk/256, MSB one BCLK after LRCLK edge.
// Define OSCILL_AUDIO_UNDERRUN_CNT_EN to add the saturating 16-bit underrun_count output.
module oscill_nios_audio_i2s_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_right,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  dacdat,
  output logic                  underrun
`ifdef OSCILL_AUDIO_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic                  lock_meta_reg;
  logic                  lock_s_reg;
  logic [7:0]            cnt_reg;
  logic [7:0]            cnt_next;
  logic [AW:0]           wr_ptr_reg;
  logic [AW:0]           rd_ptr_reg;
  logic [AW:0]           fill;
  logic [DATA_WIDTH-1:0] mem_left  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_right [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] left_reg;
  logic [DATA_WIDTH-1:0] right_reg;
  logic                  dacdat_reg;
  logic                  underrun_reg;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  fetch;
  logic [4:0]            slot_next;
  logic [DATA_WIDTH-1:0] word_next;
  logic [DATA_WIDTH-1:0] slot_hit;

  assign fill      = wr_ptr_reg - rd_ptr_reg;
  assign empty     = (fill == '0);
  assign full      = (fill == (AW+1)'(FIFO_DEPTH));
  assign in_ready  = lock_s_reg && !full;
  assign push      = in_valid && in_ready;
  assign fetch     = lock_s_reg && (cnt_reg == 8'hFF);
  assign cnt_next  = cnt_reg + 8'd1;

  // Serial bit for the slot being entered: slot k carries bit DATA_WIDTH-k, slot 0 and tail slots are 0.
  assign slot_next = cnt_next[6:2];
  assign word_next = cnt_next[7] ? right_reg : left_reg;
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_slot
    assign slot_hit[gi] = (slot_next == 5'(DATA_WIDTH - gi));
  end

  assign bclk     = cnt_reg[1];
  assign lrclk    = cnt_reg[7];
  assign dacdat   = dacdat_reg;
  assign underrun = underrun_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_left[wr_ptr_reg[AW-1:0]]  <= in_left;
      mem_right[wr_ptr_reg[AW-1:0]] <= in_right;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
      cnt_reg       <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      left_reg      <= '0;
      right_reg     <= '0;
      dacdat_reg    <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      lock_meta_reg <= pll_locked;
      lock_s_reg    <= lock_meta_reg;
      underrun_reg  <= 1'b0;
      if (!lock_s_reg) begin
        // Unlocked: park the frame timing and drop everything queued.
        cnt_reg    <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        left_reg   <= '0;
        right_reg  <= '0;
        dacdat_reg <= 1'b0;
      end else begin
        cnt_reg    <= cnt_next;
        dacdat_reg <= |(slot_hit & word_next);
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
        end
        if (fetch) begin
          if (empty) begin
            left_reg     <= '0;
            right_reg    <= '0;
            underrun_reg <= 1'b1;
          end else begin
            left_reg   <= mem_left[rd_ptr_reg[AW-1:0]];
            right_reg  <= mem_right[rd_ptr_reg[AW-1:0]];
            rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
          end
        end
      end
    end
  end

`ifdef OSCILL_AUDIO_UNDERRUN_CNT_EN
  logic [15:0] underrun_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_count_reg <= '0;
    end else if (fetch && empty && (underrun_count_reg != 16'hFFFF)) begin
      underrun_count_reg <= underrun_count_reg + 16'd1;
    end
  end

  assign underrun_count = underrun_count_reg;
`endif

endmodule

// File: tb/tb_oscill_nios_audio_i2s_tx.sv
// Directed bench for oscill_nios_audio_i2s_tx: captures serial words per frame on BCLK rising edges.
// Exercises underrun_count too when OSCILL_AUDIO_UNDERRUN_CNT_EN is defined.
module tb_oscill_nios_audio_i2s_tx;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          pll_locked;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_left;
  logic [DW-1:0] in_right;
  logic          bclk;
  logic          lrclk;
  logic          dacdat;
  logic          underrun;
`ifdef OSCILL_AUDIO_UNDERRUN_CNT_EN
  logic [15:0]   underrun_count;
`endif

  int checks   = 0;
  int failures = 0;
  int phase    = 0;
  int push_idx = 0;

  logic [15:0] tbl_l [8] = '{16'hA5A5, 16'h8001, 16'h4002, 16'h2004,
                             16'h1008, 16'h0810, 16'h0420, 16'h0240};
  logic [15:0] tbl_r [8] = '{16'h5A5A, 16'h7FFE, 16'hC003, 16'h0F0F,
                             16'hF0F0, 16'h1234, 16'hFEDC, 16'hFFFF};

  oscill_nios_audio_i2s_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_left    (in_left),
    .in_right   (in_right),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .dacdat     (dacdat),
    .underrun   (underrun)
`ifdef OSCILL_AUDIO_UNDERRUN_CNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one 256-cycle frame from cnt==0; mode 0 idle, 1 single push at start, 2 in_valid held high.
  task automatic run_frame(input string tag, input int mode, input logic [31:0] exp_l,
                           input logic [31:0] exp_r, input int exp_under, input int exp_ready);
    logic [31:0] lw;
    logic [31:0] rw;
    logic [7:0]  ph;
    logic        prev;
    logic        rdy;
    int          under;
    int          ready;
    int          clk_err;
    int          stab_err;
    int          idx;
    lw = '0; rw = '0; prev = 1'b0;
    under = 0; ready = 0; clk_err = 0; stab_err = 0;
    for (int i = 0; i < 256; i++) begin
      ph = 8'(phase);
      if (bclk !== ph[1] || lrclk !== ph[7]) clk_err++;
      if (ph[1:0] == 2'b10) begin
        idx = 31 - int'(ph[6:2]);
        if (ph[7]) rw[idx] = dacdat;
        else       lw[idx] = dacdat;
      end
      if (ph[1:0] != 2'b00 && dacdat !== prev) stab_err++;
      prev = dacdat;
      if (underrun === 1'b1) under++;
      rdy = in_ready;
      if (rdy === 1'b1) ready++;
      if (mode == 2 || (mode == 1 && i == 0)) begin
        in_valid = 1'b1;
        in_left  = tbl_l[push_idx];
        in_right = tbl_r[push_idx];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      phase = (phase + 1) % 256;
      if (in_valid && rdy === 1'b1) push_idx++;
    end
    in_valid = 1'b0;
    chk({tag, "_left_word"}, lw, exp_l);
    chk({tag, "_right_word"}, rw, exp_r);
    chk({tag, "_underrun_cycles"}, 32'(under), 32'(exp_under));
    chk({tag, "_ready_cycles"}, 32'(ready), 32'(exp_ready));
    chk({tag, "_bclk_lrclk_errors"}, 32'(clk_err), 32'd0);
    chk({tag, "_dacdat_midslot_changes"}, 32'(stab_err), 32'd0);
  endtask

  initial begin
    int err;
    rst = 1'b1; pll_locked = 1'b0; in_valid = 1'b0; in_left = '0; in_right = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_bclk", bclk, 0);
    chk("reset_lrclk", lrclk, 0);
    chk("reset_dacdat", dacdat, 0);
    chk("reset_underrun", underrun, 0);
    chk("reset_in_ready", in_ready, 0);
`ifdef OSCILL_AUDIO_UNDERRUN_CNT_EN
    chk("reset_underrun_count", underrun_count, 0);
`endif

    // Lock: in_ready rises on the second edge, counter starts from 0 there.
    pll_locked = 1'b1;
    tick();
    chk("lock_ready_edge1", in_ready, 0);
    tick();
    chk("lock_ready_edge2", in_ready, 1);
    phase = 0;

    run_frame("f0", 1, 32'h0000_0000, 32'h0000_0000, 0, 256);
    run_frame("f1", 0, 32'h52D2_8000, 32'h2D2D_0000, 0, 256);
    run_frame("f2", 0, 32'h0000_0000, 32'h0000_0000, 1, 256);
    run_frame("f3", 0, 32'h0000_0000, 32'h0000_0000, 1, 256);
    chk("f4_start_underrun", underrun, 1);
`ifdef OSCILL_AUDIO_UNDERRUN_CNT_EN
    chk("underrun_count_3", underrun_count, 3);
`endif

    // Back-pressure: four pairs fill the FIFO, then one slot opens per fetch.
    run_frame("f4", 2, 32'h0000_0000, 32'h0000_0000, 1, 4);
    run_frame("f5", 2, 32'h4000_8000, 32'h3FFF_0000, 0, 1);
    run_frame("f6", 2, 32'h2001_0000, 32'h6001_8000, 0, 1);
    chk("f7_ready_with_3_queued", in_ready, 1);

    // Lose lock at cnt==60 with three entries queued.
    repeat (60) tick();
    pll_locked = 1'b0;
    tick();
    tick();
    chk("unlock_ready_edge2", in_ready, 0);
    tick();
    chk("unlock_bclk", bclk, 0);
    chk("unlock_lrclk", lrclk, 0);
    chk("unlock_dacdat", dacdat, 0);
    chk("unlock_in_ready", in_ready, 0);
    err = 0;
    for (int i = 0; i < 20; i++) begin
      if (underrun !== 1'b0 || bclk !== 1'b0 || lrclk !== 1'b0 || dacdat !== 1'b0 || in_ready !== 1'b0) err++;
      tick();
    end
    chk("unlocked_quiet_errors", 32'(err), 0);

    pll_locked = 1'b1;
    tick();
    tick();
    phase = 0;
    chk("relock_ready", in_ready, 1);
    run_frame("r0", 0, 32'h0000_0000, 32'h0000_0000, 0, 256);
    chk("relock_first_fetch_underrun", underrun, 1);
`ifdef OSCILL_AUDIO_UNDERRUN_CNT_EN
    chk("underrun_count_4", underrun_count, 4);
`endif

    // Queue a pair, then reset in the right half of the frame that plays it.
    in_valid = 1'b1; in_left = tbl_l[7]; in_right = tbl_r[7];
    tick();
    in_valid = 1'b0;
    repeat (255 + 142) tick();
    chk("pre_reset_lrclk", lrclk, 1);
    chk("pre_reset_bclk", bclk, 1);
    chk("pre_reset_dacdat", dacdat, 1);
    rst = 1'b1;
    tick();
    chk("midframe_reset_bclk", bclk, 0);
    chk("midframe_reset_lrclk", lrclk, 0);
    chk("midframe_reset_dacdat", dacdat, 0);
    chk("midframe_reset_underrun", underrun, 0);
    chk("midframe_reset_in_ready", in_ready, 0);
`ifdef OSCILL_AUDIO_UNDERRUN_CNT_EN
    chk("midframe_reset_underrun_count", underrun_count, 0);
`endif
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oscill_nios_audio_i2s_tx.md
# oscill_nios_audio_i2s_tx

I2S audio transmitter clocked by the 12.288 MHz audio PLL output; consumes the PLL's clock and `locked` and drives the codec DAC serial interface. Stereo samples are accepted from the Nios-side streaming path through a valid/ready handshake and buffered in a small FIFO. The block derives BCLK (3.072 MHz) and LRCLK (48 kHz) by dividing the audio clock, then serializes one stereo frame per LRCLK period.

## Interface
- `DATA_WIDTH`, 16, sample width per channel, 1..31.
- `FIFO_DEPTH`, 4, stereo-frame FIFO entries, power of two, ≥2.

- `clk`  in  1  audio clock, 12.288 MHz, from PLL `outclk_0`.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `pll_locked`  in  1  PLL `locked`; asynchronous, synchronized internally with two flops.
- `in_valid`  in  1  sample pair valid.
- `in_ready`  out  1  FIFO can accept a pair.
- `in_left`  in  DATA_WIDTH  left sample, two's complement.
- `in_right`  in  DATA_WIDTH  right sample, two's complement.
- `bclk`  out  1  bit clock, clk/4.
- `lrclk`  out  1  word select; 0 = left, 1 = right.
- `dacdat`  out  1  serial data, MSB first.
- `underrun`  out  1  one-cycle pulse: frame fetch found FIFO empty.

## Operation
- Free-running 8-bit counter `cnt`, incremented every `clk` while `lock_s` (synchronized `pll_locked`) is 1.
- `bclk = cnt[1]`, `lrclk = cnt[7]`, slot index `k = cnt[6:2]` (0..31), all registered.
- Frame: `cnt` 0..127 is the left half, 128..255 is the right half.
- Slot k carries sample bit `DATA_WIDTH-k` for 1 ≤ k ≤ DATA_WIDTH, otherwise 0 (I2S one-BCLK MSB delay).
- Fetch: on the cycle with `cnt == 255`, pop one FIFO entry into the left/right shift registers, used for the frame starting at `cnt == 0`.
  - If the FIFO is empty, load zeros and pulse `underrun`.
- Handshake:
  - `in_ready = lock_s && !full`.
  - A transfer occurs when `in_valid && in_ready` at a rising edge.
  - `in_left`/`in_right` are only sampled on a transfer.
- Simultaneous push and pop: both take effect; occupancy is unchanged.
  - Push into an empty FIFO in the same cycle as a fetch: the fetch underruns and the pushed entry remains for the next frame.
- `lock_s == 0`, including a mid-frame loss of lock:
  - `cnt` is held at 0; `bclk`, `lrclk`, `dacdat` are 0.
  - FIFO is flushed; `in_ready` is 0; no `underrun` pulses.
  - On relock, `cnt` restarts at 0.
- Reset:
  - Outputs `bclk`, `lrclk`, `dacdat`, `underrun`, `in_ready` = 0.
  - `cnt` = 0, FIFO empty, synchronizer flops = 0.
  - Reset asserted mid-frame aborts the frame immediately.

## Timing
- `pll_locked` rise to `in_ready` = 1: two `clk` edges, given the FIFO is not full.
- `dacdat` changes only on `bclk` falling edges (cnt[1:0] 11→00); the codec samples on rising edges.
- Latency from a transfer into an empty FIFO to its left MSB on `dacdat`: MSB is driven during the slot-1 window of the frame that starts after the next `cnt == 255` fetch, i.e. from `cnt == 4` of that frame.
- Throughput is one stereo pair per 256 `clk` cycles (48 kHz).
- `underrun` is high for exactly one cycle, on the cycle following the `cnt == 255` edge.

## Configuration
- `OSCILL_AUDIO_UNDERRUN_CNT_EN` defined:
  - Adds output `underrun_count` (16-bit).
  - Increments on each `underrun` pulse and saturates at 0xFFFF.
  - Cleared by `rst` only; holds its value while unlocked.
- `OSCILL_AUDIO_UNDERRUN_CNT_EN` undefined: the port and the counter do not exist; all other behaviour is identical.

## Test plan
- Reset, then `pll_locked`=1 → `in_ready`=0 for 2 edges, then 1; `bclk` period 4 clk, `lrclk` period 256 clk, 50% duty.
- Push L=0xA5A5, R=0x5A5A (DATA_WIDTH=16) → serial captured on `bclk` rising edges:
  - Left slots 1..16 = 0xA5A5; right slots 1..16 = 0x5A5A.
  - Slots 0 and 17..31 = 0; no `underrun` for that frame.
- No pushes for 3 frames → `dacdat` constant 0; `underrun` pulses 3 times, 256 clk apart; `underrun_count`=3 with macro defined.
- Hold `in_valid`=1 with frame generation running:
  - `in_ready` drops after 4 accepted pairs.
  - Rises for 1 cycle after each `cnt == 255` fetch; pairs emerge in push order.
- Drop `pll_locked` at `cnt` = 60 with 3 entries queued:
  - Within 3 edges `bclk`/`lrclk`/`dacdat`/`in_ready` = 0 and the FIFO is empty.
  - After relock, the first frame underruns.
- Assert `rst` for 1 cycle mid-right-half → all outputs 0 on the next edge; `underrun_count` = 0.
